// File: rtl/delta_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delta_ctrl_pkg                                             |
// | Description : Shared definitions for the LSTM backprop delta sequencer:  |
// |               FSM state encoding, gate identifiers, select-vector layout |
// |               and the per-cycle select schedule of the delta datapath.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package delta_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_WAIT   = 4'd1,
      ST_LOAD   = 4'd2,
      ST_DSTATE = 4'd3,
      ST_GATE_A = 4'd4,
      ST_GATE_I = 4'd5,
      ST_GATE_F = 4'd6,
      ST_GATE_O = 4'd7,
      ST_DONE   = 4'd8
   } state_t;

   localparam logic [1:0] C_GATE_ID_A = 2'd0;
   localparam logic [1:0] C_GATE_ID_I = 2'd1;
   localparam logic [1:0] C_GATE_ID_F = 2'd2;
   localparam logic [1:0] C_GATE_ID_O = 2'd3;

   // Each compute phase lasts four cycles; the result strobe fires on the last.
   localparam logic [1:0] C_SUB_LAST  = 2'd3;

   localparam int C_SEL_IN1_W    = 2;
   localparam int C_SEL_IN2_W    = 2;
   localparam int C_SEL_IN3_W    = 1;
   localparam int C_SEL_IN4_W    = 2;
   localparam int C_SEL_IN5_W    = 3;
   localparam int C_SEL_X1_1_W   = 2;
   localparam int C_SEL_X1_2_W   = 1;
   localparam int C_SEL_X2_2_W   = 2;
   localparam int C_SEL_AS_1_W   = 1;
   localparam int C_SEL_AS_2_W   = 2;
   localparam int C_SEL_ADDSUB_W = 1;
   localparam int C_SEL_TEMP_W   = 2;

   // Field order is also the positional order used in the constant tables.
   typedef struct packed {
      logic [C_SEL_IN1_W-1:0]    sel_in1;
      logic [C_SEL_IN2_W-1:0]    sel_in2;
      logic [C_SEL_IN3_W-1:0]    sel_in3;
      logic [C_SEL_IN4_W-1:0]    sel_in4;    // 0 d_out, 1 h, 3 zero
      logic [C_SEL_IN5_W-1:0]    sel_in5;    // 0 t, 5 zero
      logic [C_SEL_X1_1_W-1:0]   sel_x1_1;
      logic [C_SEL_X1_2_W-1:0]   sel_x1_2;
      logic [C_SEL_X2_2_W-1:0]   sel_x2_2;
      logic [C_SEL_AS_1_W-1:0]   sel_as_1;
      logic [C_SEL_AS_2_W-1:0]   sel_as_2;
      logic [C_SEL_ADDSUB_W-1:0] sel_addsub;
      logic [C_SEL_TEMP_W-1:0]   sel_temp;   // 2 hold, 3 clear
   } sel_vec_t;

   // Quiescent vector: zero operands on in4/in5, temp register holds.
   localparam sel_vec_t C_SEL_IDLE =
      '{2'd0, 2'd0, 1'b0, 2'd3, 3'd5, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2};
   // Newest timestep: seed from h and t, and clear the temp accumulator.
   localparam sel_vec_t C_SEL_LOAD_FIRST =
      '{2'd0, 2'd0, 1'b0, 2'd1, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd3};
   // Older timesteps: take the propagated d_out and keep temp.
   localparam sel_vec_t C_SEL_LOAD_NEXT =
      '{2'd0, 2'd0, 1'b0, 2'd0, 3'd5, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2};

   localparam int C_SCHED_LEN = 20;

   // Row index = phase*4 + sub-count, phase 0 = DSTATE, 1..4 = gates a,i,f,o.
   localparam sel_vec_t C_SCHED_TBL [0:C_SCHED_LEN-1] = '{
      '{2'd0, 2'd1, 1'b0, 2'd0, 3'd1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0},
      '{2'd1, 2'd1, 1'b0, 2'd0, 3'd2, 2'd1, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 2'd0},
      '{2'd1, 2'd2, 1'b1, 2'd0, 3'd2, 2'd1, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 2'd1},
      '{2'd2, 2'd2, 1'b1, 2'd0, 3'd3, 2'd2, 1'b0, 2'd1, 1'b1, 2'd2, 1'b0, 2'd1},
      '{2'd0, 2'd0, 1'b0, 2'd2, 3'd4, 2'd0, 1'b0, 2'd2, 1'b0, 2'd0, 1'b1, 2'd0},
      '{2'd0, 2'd3, 1'b0, 2'd2, 3'd4, 2'd3, 1'b1, 2'd2, 1'b0, 2'd3, 1'b1, 2'd1},
      '{2'd3, 2'd3, 1'b1, 2'd2, 3'd0, 2'd3, 1'b0, 2'd3, 1'b1, 2'd3, 1'b0, 2'd1},
      '{2'd3, 2'd0, 1'b1, 2'd1, 3'd0, 2'd2, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd2},
      '{2'd1, 2'd0, 1'b0, 2'd2, 3'd1, 2'd0, 1'b1, 2'd2, 1'b0, 2'd1, 1'b1, 2'd0},
      '{2'd1, 2'd3, 1'b1, 2'd2, 3'd1, 2'd1, 1'b0, 2'd1, 1'b1, 2'd2, 1'b1, 2'd1},
      '{2'd2, 2'd3, 1'b0, 2'd3, 3'd2, 2'd3, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 2'd1},
      '{2'd2, 2'd1, 1'b1, 2'd1, 3'd3, 2'd2, 1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 2'd2},
      '{2'd0, 2'd2, 1'b1, 2'd2, 3'd2, 2'd1, 1'b1, 2'd2, 1'b0, 2'd1, 1'b1, 2'd0},
      '{2'd3, 2'd2, 1'b0, 2'd0, 3'd3, 2'd1, 1'b0, 2'd1, 1'b1, 2'd2, 1'b1, 2'd1},
      '{2'd3, 2'd1, 1'b1, 2'd3, 3'd4, 2'd0, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 2'd1},
      '{2'd1, 2'd1, 1'b0, 2'd1, 3'd5, 2'd2, 1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 2'd2},
      '{2'd2, 2'd0, 1'b1, 2'd2, 3'd3, 2'd3, 1'b0, 2'd2, 1'b1, 2'd1, 1'b1, 2'd0},
      '{2'd2, 2'd3, 1'b0, 2'd0, 3'd4, 2'd0, 1'b1, 2'd1, 1'b0, 2'd2, 1'b1, 2'd1},
      '{2'd0, 2'd1, 1'b1, 2'd3, 3'd1, 2'd1, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd1},
      '{2'd1, 2'd2, 1'b0, 2'd1, 3'd0, 2'd3, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd2}
   };

   // Table row for a compute state; only meaningful for DSTATE..GATE_O.
   function automatic logic [4:0] sched_idx(input state_t st, input logic [1:0] sub);
      logic [3:0] phase;
      phase = 4'(st) - 4'(ST_DSTATE);
      return {phase[2:0], sub};
   endfunction

   // Phase that follows a compute phase once its last sub-step completes.
   function automatic state_t next_phase(input state_t st);
      state_t nxt;
      case (st)
         ST_DSTATE: nxt = ST_GATE_A;
         ST_GATE_A: nxt = ST_GATE_I;
         ST_GATE_I: nxt = ST_GATE_F;
         ST_GATE_F: nxt = ST_GATE_O;
         default:   nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/delta_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delta_ctrl_if                                              |
// | Description : Control bundle between the delta sequencer and the delta   |
// |               datapath / operand memory side.                            |
// |   master : sequencer (drives status, strobes, indices, selects)          |
// |   slave  : datapath/memory side (drives start, opnd_valid)               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface delta_ctrl_if #(
   parameter int UW = 4,
   parameter int TW = 3
) ();
   logic          start;
   logic          opnd_valid;
   logic          busy;
   logic          done;
   logic          opnd_req;
   logic [UW-1:0] unit_idx;
   logic [TW-1:0] step_idx;
   logic          dstate_valid;
   logic          dgate_valid;
   logic [1:0]    gate_id;
   logic [1:0]    sel_in1;
   logic [1:0]    sel_in2;
   logic          sel_in3;
   logic [1:0]    sel_in4;
   logic [2:0]    sel_in5;
   logic [1:0]    sel_x1_1;
   logic          sel_x1_2;
   logic [1:0]    sel_x2_2;
   logic          sel_as_1;
   logic [1:0]    sel_as_2;
   logic          sel_addsub;
   logic [1:0]    sel_temp;

   modport master (
      input  start, opnd_valid,
      output busy, done, opnd_req, unit_idx, step_idx,
      output dstate_valid, dgate_valid, gate_id,
      output sel_in1, sel_in2, sel_in3, sel_in4, sel_in5,
      output sel_x1_1, sel_x1_2, sel_x2_2, sel_as_1, sel_as_2, sel_addsub, sel_temp
   );

   modport slave (
      output start, opnd_valid,
      input  busy, done, opnd_req, unit_idx, step_idx,
      input  dstate_valid, dgate_valid, gate_id,
      input  sel_in1, sel_in2, sel_in3, sel_in4, sel_in5,
      input  sel_x1_1, sel_x1_2, sel_x2_2, sel_as_1, sel_as_2, sel_addsub, sel_temp
   );
endinterface
`default_nettype wire

// File: rtl/delta_sched_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delta_sched_rom                                            |
// | Description : Combinational select-vector lookup for the delta datapath. |
// |   i_state      : sequencer state the vector is for                       |
// |   i_sub        : phase sub-count (0..3)                                  |
// |   i_first_step : current timestep is the newest one                      |
// |   o_sel        : packed select vector                                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module delta_sched_rom
   import delta_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [1:0] i_sub,
   input  logic       i_first_step,
   output sel_vec_t   o_sel
);

   always_comb begin
      o_sel = C_SEL_IDLE;
      case (i_state)
         ST_LOAD:   o_sel = i_first_step ? C_SEL_LOAD_FIRST : C_SEL_LOAD_NEXT;
         ST_DSTATE,
         ST_GATE_A,
         ST_GATE_I,
         ST_GATE_F,
         ST_GATE_O: o_sel = C_SCHED_TBL[sched_idx(i_state, i_sub)];
         default:   o_sel = C_SEL_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/delta_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delta_ctrl                                                 |
// | Description : Sequencer for the LSTM backprop delta datapath. Walks all  |
// |               hidden units of every timestep (newest timestep first),    |
// |               fetches operands per unit and drives the datapath selects  |
// |               and result strobes cycle by cycle.                         |
// |   clk   : clock                                                          |
// |   rst_n : asynchronous active-low reset                                  |
// |   bus   : delta_ctrl_if.master (start/opnd_valid in, status, strobes,    |
// |           unit/step indices and all datapath selects out)                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module delta_ctrl
   import delta_ctrl_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNITS  = 16,
   parameter int TSTEPS = 8,
   parameter int UW     = 4,
   parameter int TW     = 3
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   delta_ctrl_if.master      bus
);

   localparam logic [UW-1:0] C_UNIT_LAST  = UW'(UNITS - 1);
   localparam logic [TW-1:0] C_STEP_FIRST = TW'(TSTEPS - 1);

   // WIDTH only travels with the datapath; reject configurations that cannot work.
   if (WIDTH < 1 || UNITS < 1 || TSTEPS < 1 ||
       (1 << UW) < UNITS || (1 << TW) < TSTEPS) begin : g_param_check
      $error("delta_ctrl: inconsistent WIDTH/UNITS/TSTEPS/UW/TW");
   end

   state_t        state_q, state_d;
   logic [1:0]    sub_q, sub_d;
   logic [UW-1:0] unit_q, unit_d;
   logic [TW-1:0] step_q, step_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          opnd_req_q, opnd_req_d;
   logic          dstate_valid_q, dstate_valid_d;
   logic          dgate_valid_q, dgate_valid_d;
   logic [1:0]    gate_id_q, gate_id_d;
   sel_vec_t      sel_q, sel_d;
   logic          first_step_d;

   // Next-state and counter update.
   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      unit_d  = unit_q;
      step_d  = step_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.opnd_valid) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d = ST_DSTATE;
            sub_d   = 2'd0;
         end
         ST_DSTATE, ST_GATE_A, ST_GATE_I, ST_GATE_F: begin
            sub_d = sub_q + 2'd1;
            if (sub_q == C_SUB_LAST) state_d = next_phase(state_q);
         end
         ST_GATE_O: begin
            sub_d = sub_q + 2'd1;
            if (sub_q == C_SUB_LAST) begin
               if (unit_q != C_UNIT_LAST) begin
                  unit_d  = unit_q + UW'(1);
                  state_d = ST_WAIT;
               end else begin
                  unit_d = '0;
                  if (step_q != '0) begin
                     step_d  = step_q - TW'(1);
                     state_d = ST_WAIT;
                  end else begin
                     // Reload now so DONE and IDLE already show the newest step.
                     step_d  = C_STEP_FIRST;
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            sub_d   = 2'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line
   // up with the state they describe.
   always_comb begin
      busy_d         = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d         = (state_d == ST_DONE);
      opnd_req_d     = (state_d == ST_WAIT);
      dstate_valid_d = (state_d == ST_DSTATE) && (sub_d == C_SUB_LAST);
      dgate_valid_d  = 1'b0;
      gate_id_d      = C_GATE_ID_A;
      case (state_d)
         ST_GATE_A: gate_id_d = C_GATE_ID_A;
         ST_GATE_I: gate_id_d = C_GATE_ID_I;
         ST_GATE_F: gate_id_d = C_GATE_ID_F;
         ST_GATE_O: gate_id_d = C_GATE_ID_O;
         default:   gate_id_d = C_GATE_ID_A;
      endcase
      if ((state_d == ST_GATE_A) || (state_d == ST_GATE_I) ||
          (state_d == ST_GATE_F) || (state_d == ST_GATE_O)) begin
         dgate_valid_d = (sub_d == C_SUB_LAST);
      end
      first_step_d = (step_d == C_STEP_FIRST);
   end

   delta_sched_rom u_sched_rom (
      .i_state      (state_d),
      .i_sub        (sub_d),
      .i_first_step (first_step_d),
      .o_sel        (sel_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         sub_q          <= 2'd0;
         unit_q         <= '0;
         step_q         <= C_STEP_FIRST;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         opnd_req_q     <= 1'b0;
         dstate_valid_q <= 1'b0;
         dgate_valid_q  <= 1'b0;
         gate_id_q      <= C_GATE_ID_A;
         sel_q          <= C_SEL_IDLE;
      end else begin
         state_q        <= state_d;
         sub_q          <= sub_d;
         unit_q         <= unit_d;
         step_q         <= step_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         opnd_req_q     <= opnd_req_d;
         dstate_valid_q <= dstate_valid_d;
         dgate_valid_q  <= dgate_valid_d;
         gate_id_q      <= gate_id_d;
         sel_q          <= sel_d;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.opnd_req     = opnd_req_q;
   assign bus.unit_idx     = unit_q;
   assign bus.step_idx     = step_q;
   assign bus.dstate_valid = dstate_valid_q;
   assign bus.dgate_valid  = dgate_valid_q;
   assign bus.gate_id      = gate_id_q;
   assign bus.sel_in1      = sel_q.sel_in1;
   assign bus.sel_in2      = sel_q.sel_in2;
   assign bus.sel_in3      = sel_q.sel_in3;
   assign bus.sel_in4      = sel_q.sel_in4;
   assign bus.sel_in5      = sel_q.sel_in5;
   assign bus.sel_x1_1     = sel_q.sel_x1_1;
   assign bus.sel_x1_2     = sel_q.sel_x1_2;
   assign bus.sel_x2_2     = sel_q.sel_x2_2;
   assign bus.sel_as_1     = sel_q.sel_as_1;
   assign bus.sel_as_2     = sel_q.sel_as_2;
   assign bus.sel_addsub   = sel_q.sel_addsub;
   assign bus.sel_temp     = sel_q.sel_temp;

endmodule
`default_nettype wire

// File: tb/tb_delta_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_delta_ctrl                                              |
// | Description : Self-checking bench for delta_ctrl. A 2-unit/2-step        |
// |               instance is walked pass by pass against a nested-loop      |
// |               reference of the unit/timestep schedule; a 1x1 instance    |
// |               covers the degenerate counter configuration.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_delta_ctrl;
   import delta_ctrl_pkg::*;

   localparam int C_UNITS  = 2;
   localparam int C_TSTEPS = 2;

   logic clk;
   logic rst_n;

   int n_tests;
   int n_fail;
   int n_dstate;
   logic [1:0] gate_q[$];

   delta_ctrl_if #(.UW(1), .TW(1)) ifa ();
   delta_ctrl_if #(.UW(1), .TW(1)) ifb ();

   delta_ctrl #(
      .WIDTH(32), .UNITS(C_UNITS), .TSTEPS(C_TSTEPS), .UW(1), .TW(1)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.master)
   );

   delta_ctrl #(
      .WIDTH(32), .UNITS(1), .TSTEPS(1), .UW(1), .TW(1)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor for instance A, sampled on the inactive edge.
   always @(negedge clk) begin
      if (ifa.dstate_valid === 1'b1) n_dstate++;
      if (ifa.dgate_valid === 1'b1) gate_q.push_back(ifa.gate_id);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic sel_vec_t obs_sel();
      sel_vec_t v;
      v.sel_in1    = ifa.sel_in1;
      v.sel_in2    = ifa.sel_in2;
      v.sel_in3    = ifa.sel_in3;
      v.sel_in4    = ifa.sel_in4;
      v.sel_in5    = ifa.sel_in5;
      v.sel_x1_1   = ifa.sel_x1_1;
      v.sel_x1_2   = ifa.sel_x1_2;
      v.sel_x2_2   = ifa.sel_x2_2;
      v.sel_as_1   = ifa.sel_as_1;
      v.sel_as_2   = ifa.sel_as_2;
      v.sel_addsub = ifa.sel_addsub;
      v.sel_temp   = ifa.sel_temp;
      return v;
   endfunction

   // One in-pass cycle of instance A.
   task automatic check_cyc(input string tag, input sel_vec_t esel, input bit ereq,
                            input bit edsv, input bit edgv, input logic [1:0] egid,
                            input int eu, input int es);
      check_eq({tag, ".sel"},      32'(obs_sel()),         32'(esel));
      check_eq({tag, ".busy"},     32'(ifa.busy),          32'(1));
      check_eq({tag, ".done"},     32'(ifa.done),          32'(0));
      check_eq({tag, ".opnd_req"}, 32'(ifa.opnd_req),      32'(ereq));
      check_eq({tag, ".dstate_v"}, 32'(ifa.dstate_valid),  32'(edsv));
      check_eq({tag, ".dgate_v"},  32'(ifa.dgate_valid),   32'(edgv));
      check_eq({tag, ".unit"},     32'(ifa.unit_idx),      32'(eu));
      check_eq({tag, ".step"},     32'(ifa.step_idx),      32'(es));
      if (edgv) check_eq({tag, ".gate_id"}, 32'(ifa.gate_id), 32'(egid));
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, ".busy"},     32'(ifa.busy),         32'(0));
      check_eq({tag, ".done"},     32'(ifa.done),         32'(0));
      check_eq({tag, ".opnd_req"}, 32'(ifa.opnd_req),     32'(0));
      check_eq({tag, ".dstate_v"}, 32'(ifa.dstate_valid), 32'(0));
      check_eq({tag, ".dgate_v"},  32'(ifa.dgate_valid),  32'(0));
      check_eq({tag, ".gate_id"},  32'(ifa.gate_id),      32'(0));
      check_eq({tag, ".unit"},     32'(ifa.unit_idx),     32'(0));
      check_eq({tag, ".step"},     32'(ifa.step_idx),     32'(C_TSTEPS - 1));
      check_eq({tag, ".sel_in4"},  32'(ifa.sel_in4),      32'(3));
      check_eq({tag, ".sel_in5"},  32'(ifa.sel_in5),      32'(5));
      check_eq({tag, ".sel_temp"}, 32'(ifa.sel_temp),     32'(2));
      check_eq({tag, ".sel"},      32'(obs_sel()),        32'(C_SEL_IDLE));
   endtask

   task automatic drive_noise(input bit noise);
      ifa.opnd_valid = noise ? 1'($urandom) : 1'b1;
   endtask

   // One full pass: timesteps newest-first, units in order, each unit is
   // WAIT (1+stall) -> LOAD -> 5 phases x 4 sub-steps.
   task automatic run_pass(input bit hold, input int stall_first, input int stall_max,
                           input bit noise);
      int       stall;
      int       stall_tot;
      int       edges;
      bit       first;
      sel_vec_t load_sel;
      n_dstate  = 0;
      gate_q.delete();
      edges     = 0;
      stall_tot = 0;
      first     = 1'b1;
      ifa.start = 1'b1;
      tick();
      edges++;
      if (!hold) ifa.start = 1'b0;
      for (int st = C_TSTEPS - 1; st >= 0; st--) begin
         for (int un = 0; un < C_UNITS; un++) begin
            stall = first ? stall_first : int'($urandom_range(stall_max, 0));
            first = 1'b0;
            stall_tot += stall;
            for (int w = 0; w <= stall; w++) begin
               check_cyc("wait", C_SEL_IDLE, 1'b1, 1'b0, 1'b0, 2'd0, un, st);
               ifa.opnd_valid = (w == stall);
               tick();
               edges++;
            end
            load_sel = (st == C_TSTEPS - 1) ? C_SEL_LOAD_FIRST : C_SEL_LOAD_NEXT;
            check_cyc("load", load_sel, 1'b0, 1'b0, 1'b0, 2'd0, un, st);
            if (st == C_TSTEPS - 1) begin
               check_eq("load_first.sel_in4",  32'(ifa.sel_in4),  32'(1));
               check_eq("load_first.sel_in5",  32'(ifa.sel_in5),  32'(0));
               check_eq("load_first.sel_temp", 32'(ifa.sel_temp), 32'(3));
            end else begin
               check_eq("load_next.sel_in4",  32'(ifa.sel_in4),  32'(0));
               check_eq("load_next.sel_temp", 32'(ifa.sel_temp), 32'(2));
            end
            drive_noise(noise);
            for (int ph = 0; ph < 5; ph++) begin
               for (int sb = 0; sb < 4; sb++) begin
                  tick();
                  edges++;
                  check_cyc((ph == 0) ? "dstate" : "gate", C_SCHED_TBL[ph*4 + sb], 1'b0,
                            (ph == 0) && (sb == 3), (ph != 0) && (sb == 3),
                            2'(ph - 1), un, st);
                  drive_noise(noise);
               end
            end
            tick();
            edges++;
         end
      end
      check_eq("done.pulse",    32'(ifa.done),     32'(1));
      check_eq("done.busy",     32'(ifa.busy),     32'(0));
      check_eq("done.opnd_req", 32'(ifa.opnd_req), 32'(0));
      check_eq("done.sel",      32'(obs_sel()),    32'(C_SEL_IDLE));
      check_eq("pass.cycles",   32'(edges), 32'(C_TSTEPS*C_UNITS*22 + 1 + stall_tot));
      tick();
      check_eq("idle.done", 32'(ifa.done),     32'(0));
      check_eq("idle.busy", 32'(ifa.busy),     32'(0));
      check_eq("idle.step", 32'(ifa.step_idx), 32'(C_TSTEPS - 1));
      check_eq("idle.unit", 32'(ifa.unit_idx), 32'(0));
      check_eq("strobe.n_dstate", 32'(n_dstate),      32'(C_TSTEPS*C_UNITS));
      check_eq("strobe.n_dgate",  32'(gate_q.size()), 32'(4*C_TSTEPS*C_UNITS));
      foreach (gate_q[i]) check_eq("strobe.gate_order", 32'(gate_q[i]), 32'(i % 4));
   endtask

   task automatic run_single();
      int n;
      int nds;
      int ndg;
      nds = 0;
      ndg = 0;
      ifb.opnd_valid = 1'b1;
      ifb.start      = 1'b1;
      tick();
      ifb.start = 1'b0;
      n = 1;
      while (ifb.done !== 1'b1 && n < 200) begin
         check_eq("u1.unit", 32'(ifb.unit_idx), 32'(0));
         check_eq("u1.step", 32'(ifb.step_idx), 32'(0));
         if (ifb.dstate_valid === 1'b1) nds++;
         if (ifb.dgate_valid === 1'b1) ndg++;
         tick();
         n++;
      end
      check_eq("u1.cycles",   32'(n),   32'(1*1*22 + 1));
      check_eq("u1.n_dstate", 32'(nds), 32'(1));
      check_eq("u1.n_dgate",  32'(ndg), 32'(4));
      check_eq("u1.done_busy", 32'(ifb.busy), 32'(0));
      tick();
      check_eq("u1.idle_done", 32'(ifb.done), 32'(0));
      check_eq("u1.idle_busy", 32'(ifb.busy), 32'(0));
   endtask

   initial begin
      n_tests        = 0;
      n_fail         = 0;
      n_dstate       = 0;
      rst_n          = 1'b0;
      ifa.start      = 1'b0;
      ifa.opnd_valid = 1'b0;
      ifb.start      = 1'b0;
      ifb.opnd_valid = 1'b0;
      repeat (3) tick();
      check_reset_vals("rst_init");
      rst_n = 1'b1;
      tick();
      check_reset_vals("idle_after_rst");

      // opnd_valid tied high: no stall anywhere, 89-cycle pass.
      ifa.opnd_valid = 1'b1;
      run_pass(1'b0, 0, 0, 1'b0);

      // Five-cycle operand stall on the first unit.
      run_pass(1'b0, 5, 0, 1'b0);

      // start held through two passes; opnd_valid noise outside WAIT.
      run_pass(1'b1, 0, 3, 1'b1);
      run_pass(1'b1, 2, 3, 1'b1);
      ifa.start = 1'b0;
      tick();
      check_eq("start_release.busy", 32'(ifa.busy), 32'(0));

      for (int p = 0; p < 3; p++) run_pass(1'b0, int'($urandom_range(4, 0)), 4, 1'b1);

      // Reset in GATE_F sub-step 1 of the first unit.
      n_dstate = 0;
      gate_q.delete();
      ifa.start = 1'b1;
      tick();
      ifa.start      = 1'b0;
      ifa.opnd_valid = 1'b1;
      tick();
      repeat (14) tick();
      check_eq("pre_rst.gate_f", 32'(ifa.gate_id), 32'(2));
      rst_n = 1'b0;
      #2;
      check_reset_vals("rst_async");
      tick();
      check_reset_vals("rst_mid");
      check_eq("rst_mid.n_dstate", 32'(n_dstate),      32'(1));
      check_eq("rst_mid.n_dgate",  32'(gate_q.size()), 32'(2));
      rst_n = 1'b1;
      tick();
      check_reset_vals("rst_release");

      run_pass(1'b0, 1, 2, 1'b1);

      run_single();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/delta_ctrl.md
Name: delta_ctrl

Overview:
- Sequencer for the LSTM backprop delta datapath (delta unit: 5 input regs, 2 multipliers, 1 add/sub, temp reg).
- Drives every select line of that datapath cycle by cycle.
- Walks all hidden units for every timestep, newest timestep first.
- Handshakes operand fetch with the memory side and strobes result-valid flags so downstream writers capture o_dgate / o_d_state.

Parameters:
WIDTH, 32, datapath word width (passed through only; no arithmetic in this block)
UNITS, 16, hidden units per timestep
TSTEPS, 8, timesteps per backprop pass
UW, 4, width of unit index, clog2(UNITS)
TW, 3, width of timestep index, clog2(TSTEPS)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start  in  1  begin a pass; sampled only in IDLE
opnd_valid  in  1  operands for (step_idx, unit_idx) present on datapath inputs
busy  out  1  high from cycle after start until DONE
done  out  1  one-cycle pulse at end of pass
opnd_req  out  1  operand fetch request
unit_idx  out  UW  current unit
step_idx  out  TW  current timestep
dstate_valid  out  1  o_d_state valid this cycle
dgate_valid  out  1  o_dgate valid this cycle
gate_id  out  2  0=a, 1=i, 2=f, 3=o; qualified by dgate_valid
sel_in1 2, sel_in2 2, sel_in3 1, sel_in4 2, sel_in5 3  out  datapath input-register selects
sel_x1_1 2, sel_x1_2 1, sel_x2_2 2, sel_as_1 1, sel_as_2 2, sel_addsub 1, sel_temp 2  out  multiplier / add-sub / temp selects

Behaviour:
- Reset (rst low, async): state=IDLE; busy=0, done=0, opnd_req=0, dstate_valid=0, dgate_valid=0, gate_id=0, unit_idx=0, step_idx=TSTEPS-1.
- Idle select vector: all selects 0 except sel_in4=3 (zero), sel_in5=5 (zero), sel_temp=2 (hold temp). The same vector is driven in IDLE, WAIT and DONE.
- All outputs are registered; selects change on clk edge.
- FSM: IDLE -> WAIT -> LOAD -> DSTATE (4 cyc) -> GATE_A, GATE_I, GATE_F, GATE_O (4 cyc each) -> next unit or DONE.
- IDLE: start=1 -> WAIT; busy=1.
- WAIT: opnd_req=1; stays until opnd_valid=1, then LOAD. opnd_valid is ignored outside WAIT.
- LOAD (1 cyc): opnd_req=0.
  - First timestep (step_idx==TSTEPS-1): sel_in4=1 (h), sel_in5=0 (t), sel_temp=3 (clear temp).
  - Otherwise: sel_in4=0 (d_out), sel_temp=2.
- Phase sub-counter: 2 bits, 0..3.
  - Select vector per (state, sub-count) is taken from the schedule constants in the package; that table is the single source of truth.
  - The bench checks against the same package.
- Strobes:
  - dstate_valid=1 in DSTATE sub-count 3.
  - dgate_valid=1 in sub-count 3 of each GATE_x, with gate_id = that gate.
  - Exactly 1 dstate strobe and 4 dgate strobes per unit, in order a, i, f, o.
- Unit latency: 21 cycles from entering LOAD to the end of GATE_O.
- After GATE_O:
  - unit_idx < UNITS-1: unit_idx+1 -> WAIT.
  - Else unit_idx=0; if step_idx>0, step_idx-1 -> WAIT; else -> DONE.
- DONE (1 cyc): done=1, busy=0 -> IDLE. step_idx reloads to TSTEPS-1.
- Boundaries:
  - start while busy: ignored.
  - start in DONE cycle: ignored; a new pass needs start in IDLE.
  - opnd_valid held high continuously: no stall; WAIT lasts exactly 1 cycle.
  - Reset mid-pass: immediate return to reset values; no strobe emitted.
  - UNITS=1 or TSTEPS=1: must work; counters wrap correctly.
- Min pass cycles: TSTEPS*UNITS*22 + 1 (start to done, inclusive of DONE, with no stalls).

Decomposition:
- Package delta_ctrl_pkg:
  - state encoding (IDLE, WAIT, LOAD, DSTATE, GATE_A, GATE_I, GATE_F, GATE_O, DONE)
  - gate_id constants
  - select-vector field widths
  - schedule constant table (20 entries: DSTATE + 4 gates x 4 sub-steps)
  - idle select vector
- One sub-module, delta_sched_rom: combinational lookup (state, sub-count) -> packed select vector, registered in delta_ctrl.
- Counters and FSM stay in delta_ctrl.

Test Plan:
- Reset: rst=0 mid-GATE_F -> next edge: busy=0, dgate_valid=0, sel_temp=2, sel_in4=3, sel_in5=5, step_idx=TSTEPS-1.
- UNITS=2, TSTEPS=2, opnd_valid tied 1, start pulse -> done exactly 89 cycles after start; 4 dstate strobes, 16 dgate strobes, gate_id order 0,1,2,3 repeating.
- First timestep LOAD -> sel_in4=1, sel_in5=0, sel_temp=3. LOAD of second timestep -> sel_in4=0, sel_temp=2.
- opnd_valid withheld 5 cycles in WAIT -> opnd_req high 5+1 cycles, no select change, pass extends by 5 cycles.
- start asserted continuously through a pass -> exactly one pass, then a second pass begins from IDLE; start during busy has no effect on counters.
- Every cycle of one unit: select vector equals the package schedule entry for (state, sub-count); any mismatch fails.
